// File: rtl/accum_reg.sv
// accum_reg: LEN-term signed accumulator with init, valid/ready result handshake and optional saturation (ACC_SATURATE_EN)
module accum_reg #(
  parameter int WIDTH = 20,
  parameter int IN_WIDTH = 16,
  parameter int LEN = 4,
  localparam int CW = $clog2(LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] d,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                en,
  input  logic                init,
  output logic [WIDTH-1:0]    out_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       cnt,
  output logic                ovf
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t state;
  logic signed [IN_WIDTH-1:0] d_s;
  logic signed [WIDTH-1:0] ext, sum, nxt;
  logic sat;
  assign d_s = d;
  assign ext = WIDTH'(d_s);
  assign sum = $signed(out_q) + ext;
  assign in_ready = state == ACC;
`ifdef ACC_SATURATE_EN
  logic of;
  // clamp toward the sign of the running sum when two same-signed operands flip sign
  always_comb begin
    of = (out_q[WIDTH-1] == ext[WIDTH-1]) && (sum[WIDTH-1] != out_q[WIDTH-1]);
    nxt = !of ? sum : out_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    sat = of;
  end
`else
  // plain modulo-2^WIDTH wrap, overflow never flagged
  always_comb begin
    nxt = sum;
    sat = 1'b0;
  end
`endif
  // state machine and registered outputs; init outranks everything except rst
  always_ff @(posedge clk) begin
    if (rst || init) begin
      state <= rst ? IDLE : ACC;
      out_q <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
    end else if (state == ACC && in_valid && en) begin
      out_q <= nxt;
      cnt <= cnt + CW'(1);
      ovf <= ovf | sat;
      if (cnt == CW'(LEN - 1)) begin
        state <= HOLD;
        out_valid <= 1'b1;
      end
    end else if (state == HOLD && out_ready) begin
      state <= ACC;
      out_q <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      ovf <= 1'b0;
    end
  end
endmodule

// File: doc/accum_reg.md
# accum_reg

Parametrised accumulating register with an initialise control, for the complex-multiplier datapath's partial-product and MAC stages. It sums LEN signed input terms into a WIDTH-bit register, presents the result under a valid/ready handshake, then clears itself and starts the next accumulation. Accumulation can be restarted at any time with `init`. It generalises the fixed 20-bit init/enable register with configurable widths, term counting, output flow control and optional saturation.

## Interface
- `WIDTH`, 20: accumulator and result width, signed two's complement.
- `IN_WIDTH`, 16: input term width, signed, sign-extended to WIDTH. Requires IN_WIDTH <= WIDTH.
- `LEN`, 4: terms per result, LEN >= 1. The counter width is $clog2(LEN+1).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  IN_WIDTH  signed input term.
- `in_valid`  in  1  `d` is presented.
- `in_ready`  out  1  block accepts a term this cycle.
- `en`  in  1  accumulate enable; gates term acceptance only.
- `init`  in  1  clear the accumulator and start a new accumulation; highest priority after `rst`.
- `out_q`  out  WIDTH  accumulated result; this is the accumulator register itself.
- `out_valid`  out  1  `out_q` holds a completed result.
- `out_ready`  in  1  consumer takes the result.
- `cnt`  out  $clog2(LEN+1)  number of terms accepted so far in the current accumulation.
- `ovf`  out  1  sticky overflow flag for the current result.

## Operation
- States: IDLE, ACC, HOLD.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, in_ready=0, ovf=0.
- IDLE: `in_ready`=0. `init` moves the block to ACC with acc=0 and cnt=0.
- ACC: `in_ready`=1.
  - A term is accepted when `in_valid` & `en` are high and `init` is low.
  - On acceptance: acc <= acc + sext(d); cnt <= cnt+1.
  - If the accepted term is the LEN-th (cnt==LEN-1 before the update), the block goes to HOLD.
- HOLD: `in_ready`=0 and `out_valid`=1. `out_q` and `cnt` (=LEN) are frozen.
  - `out_valid` & `out_ready` → ACC with acc=0, cnt=0, ovf=0 (automatic restart).
- `init` in any state → ACC, acc=0, cnt=0, ovf=0, out_valid=0.
  - A `d` presented in the same cycle is discarded.
  - An unconsumed result in HOLD is dropped.
- `en`=0 blocks acceptance only. `in_ready` still follows the state. `init`, `rst` and the output handshake are unaffected.
- Arithmetic: the WIDTH-bit signed sum is kept in full. Overflow handling is set by the configuration below.
- `rst` mid-operation returns the block to reset values on the next edge, discarding any partial sum or held result.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs except `in_ready`, which depends on state only.
- Term accepted at edge t: acc and cnt are updated after t.
- LEN-th term accepted at edge t: `out_valid`=1 and the final `out_q` are visible in the cycle following t.
- Result consumed at edge t: `in_ready`=1 and acc=0 from the following cycle. The minimum interval between consecutive results is therefore LEN+1 cycles.
- `init` asserted at edge t: the block is in ACC and ready to accept a term in the cycle following t.
- `init` has priority over `en`, over the output handshake and over acceptance.

## Configuration
- `ACC_SATURATE_EN` defined: each add clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1) on signed overflow.
  - `ovf` is set when a clamp occurs and stays set until `init`, result consumption, or `rst`.
- `ACC_SATURATE_EN` undefined: the sum wraps modulo 2^WIDTH.
  - `ovf` is tied to 0. The port remains present.

## Test plan
- Defaults. Apply `rst`, then `init`, then feed 100, 200, -50, 7 with en=1 and out_ready=1 → one cycle after the 4th term: out_valid=1, out_q=257, cnt=4. The next cycle shows acc=0, in_ready=1.
- Backpressure. Result 257 held with out_ready=0 for 3 cycles → out_valid, out_q and in_ready=0 stay constant. Then out_ready=1 → restart next cycle.
- `init` after 2 terms (100, 200), asserted together with in_valid and d=55 → acc=0, cnt=0, the 55 is not added. Next feed 1, 2, 3, 4 → out_q=10.
- en=0 with in_valid=1 for 3 cycles in ACC → acc and cnt unchanged. With en=1, 4 terms of 5 → out_q=20.
- Overflow with WIDTH=17, four terms of 32767:
  - Without `ACC_SATURATE_EN`: out_q=-4, ovf=0.
  - With `ACC_SATURATE_EN`: out_q=65535, ovf=1, and ovf clears after consumption.
- `rst` asserted in HOLD → next cycle: IDLE, out_valid=0, out_q=0, cnt=0, in_ready=0. in_valid is ignored until `init`.
